// File: rtl/jt12_pkg.sv
// -----------------------------------------------------------------------------
// jt12_pkg
// Shared definitions for the JT12 register-write scheduler:
//   - FSM state encoding (legacy-compatible localparam constants)
//   - queued write entry layout {part, reg[7:0], val[7:0]} and field offsets
//   - pack_entry() helper that builds an entry from its fields
// -----------------------------------------------------------------------------
package jt12_pkg;

  // Queued write entry: bit 16 = part, bits 15:8 = register, bits 7:0 = value
  localparam int unsigned ENTRY_W  = 17;
  localparam int unsigned PART_BIT = 16;
  localparam int unsigned REG_MSB  = 15;
  localparam int unsigned VAL_MSB  = 7;

  // Scheduler FSM states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_ADDR_W = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_DATA_W = 3'd4;
  localparam logic [2:0] ST_GAP    = 3'd5;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic       part,
                                                    input logic [7:0] reg_num,
                                                    input logic [7:0] val);
    return {part, reg_num, val};
  endfunction

endpackage

// File: rtl/jt12_wr_fifo.sv
// -----------------------------------------------------------------------------
// jt12_wr_fifo
// Posted-write FIFO, first-word fall-through, one per requester.
//   i_clk, i_rst   : clock, synchronous active-high reset (empties the FIFO)
//   i_push/i_wdata : push strobe and entry; dropped when full with no pop
//   i_pop          : consume the head entry (ignored when empty)
//   o_rdata        : head entry, valid whenever o_empty = 0
//   o_empty/o_full : occupancy flags
//   o_level        : number of stored entries (0..2**DEPTH_LOG2)
//   o_drop         : one-clock pulse after a push that was discarded
// -----------------------------------------------------------------------------
module jt12_wr_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned WIDTH      = 17
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_rdata,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_drop
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_drop;

  logic w_empty;
  logic w_full;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == LEVEL_FULL);
  assign w_pop_ok = i_pop && !w_empty;
  // A pop on the same clock frees the slot, so a push into a full FIFO still lands
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= i_push && !w_push_ok;
      // Pointers are DEPTH_LOG2 wide, so the increment wraps modulo the depth
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset; only entries below the level are ever read
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_level = r_level;
  assign o_drop  = r_drop;

endmodule

// File: rtl/jt12_wr_sched.sv
// -----------------------------------------------------------------------------
// jt12_wr_sched
// Write scheduler in front of the JT12 memory-mapped register block. Two
// requesters (port 0 = 68k, port 1 = Z80) post complete register writes into
// their own FIFO; the scheduler issues each as an address-cycle/data-cycle
// pair so the two requesters never interleave inside a pair.
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_reqN_wr/part/reg/val : port N push strobe and write fields
//   o_reqN_full/level      : port N FIFO full flag and occupancy
//   o_dropN                : port N push discarded because the FIFO was full
//   o_mmr_write            : write strobe to the register block (registered)
//   o_mmr_addr/o_mmr_din   : {part,0}/reg on address cycle, {part,1}/val on data
//   i_mmr_busy             : busy from the register block
//   o_idle                 : both FIFOs empty and FSM idle
// -----------------------------------------------------------------------------
module jt12_wr_sched
  import jt12_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned GAP        = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  // Port 0 (68k)
  input  logic                  i_req0_wr,
  input  logic                  i_req0_part,
  input  logic [7:0]            i_req0_reg,
  input  logic [7:0]            i_req0_val,
  output logic                  o_req0_full,
  output logic [DEPTH_LOG2:0]   o_req0_level,
  // Port 1 (Z80)
  input  logic                  i_req1_wr,
  input  logic                  i_req1_part,
  input  logic [7:0]            i_req1_reg,
  input  logic [7:0]            i_req1_val,
  output logic                  o_req1_full,
  output logic [DEPTH_LOG2:0]   o_req1_level,
  // Register block
  output logic                  o_mmr_write,
  output logic [1:0]            o_mmr_addr,
  output logic [7:0]            o_mmr_din,
  input  logic                  i_mmr_busy,
  // Status
  output logic                  o_idle,
  output logic                  o_drop0,
  output logic                  o_drop1
);

  localparam logic       GAP_EN   = (GAP > 0);
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  logic [2:0]         r_state;
  logic               r_prio;      // port favoured when both FIFOs hold entries
  logic [ENTRY_W-1:0] r_hold;      // entry being issued
  logic               r_mmr_write;
  logic [1:0]         r_mmr_addr;
  logic [7:0]         r_mmr_din;
  logic [3:0]         r_gap_cnt;

  logic               w_empty0;
  logic               w_empty1;
  logic [ENTRY_W-1:0] w_rdata0;
  logic [ENTRY_W-1:0] w_rdata1;
  logic               w_gnt;
  logic               w_gnt_port;
  logic               w_pop0;
  logic               w_pop1;
  logic [ENTRY_W-1:0] w_gnt_data;

  jt12_wr_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (ENTRY_W)
  ) u_fifo0 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_req0_wr),
    .i_wdata (pack_entry(i_req0_part, i_req0_reg, i_req0_val)),
    .i_pop   (w_pop0),
    .o_rdata (w_rdata0),
    .o_empty (w_empty0),
    .o_full  (o_req0_full),
    .o_level (o_req0_level),
    .o_drop  (o_drop0)
  );

  jt12_wr_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (ENTRY_W)
  ) u_fifo1 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_req1_wr),
    .i_wdata (pack_entry(i_req1_part, i_req1_reg, i_req1_val)),
    .i_pop   (w_pop1),
    .o_rdata (w_rdata1),
    .o_empty (w_empty1),
    .o_full  (o_req1_full),
    .o_level (o_req1_level),
    .o_drop  (o_drop1)
  );

  // Round-robin grant, only while idle. r_prio holds the port to favour on a
  // tie; it moves to the other port after every grant.
  always_comb begin
    w_gnt      = (r_state == ST_IDLE) && (!w_empty0 || !w_empty1);
    w_gnt_port = 1'b0;
    if (!w_empty0 && !w_empty1) begin
      w_gnt_port = r_prio;
    end else begin
      w_gnt_port = w_empty0;
    end
    w_pop0     = w_gnt && !w_gnt_port;
    w_pop1     = w_gnt && w_gnt_port;
    w_gnt_data = w_gnt_port ? w_rdata1 : w_rdata0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_prio      <= 1'b0;
      r_hold      <= '0;
      r_mmr_write <= 1'b0;
      r_mmr_addr  <= 2'b00;
      r_mmr_din   <= 8'h00;
      r_gap_cnt   <= 4'd0;
    end else begin
      r_mmr_write <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt) begin
            r_hold  <= w_gnt_data;
            r_prio  <= ~w_gnt_port;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (!i_mmr_busy) begin
            r_mmr_write <= 1'b1;
            r_mmr_addr  <= {r_hold[PART_BIT], 1'b0};
            r_mmr_din   <= r_hold[REG_MSB:VAL_MSB+1];
            r_state     <= ST_ADDR_W;
          end
        end
        // The register block raises busy one clock after it sees the strobe,
        // so busy sampled here is stale: spend one clock, then the next strobe
        // state gates on busy itself before writing.
        ST_ADDR_W: begin
          r_state <= ST_DATA;
        end
        ST_DATA: begin
          if (!i_mmr_busy) begin
            r_mmr_write <= 1'b1;
            r_mmr_addr  <= {r_hold[PART_BIT], 1'b1};
            r_mmr_din   <= r_hold[VAL_MSB:0];
            r_state     <= ST_DATA_W;
          end
        end
        ST_DATA_W: begin
          if (GAP_EN) begin
            r_gap_cnt <= GAP_LOAD;
            r_state   <= ST_GAP;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == 4'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_mmr_write = r_mmr_write;
  assign o_mmr_addr  = r_mmr_addr;
  assign o_mmr_din   = r_mmr_din;
  assign o_idle      = (r_state == ST_IDLE) && w_empty0 && w_empty1;

endmodule
